unidade_controle_vidas: RTL and testbench



---
 rtl/controle_pkg.sv | 43 ++++
 rtl/contador_timeout.sv | 36 +++
 rtl/unidade_controle_vidas.sv | 169 ++++++++++++++++
 tb/tb_unidade_controle_vidas.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/controle_pkg.sv
// Shared state codes and game-mode encodings for the lives-aware game controller.
package controle_pkg;

  localparam logic [3:0] EST_INICIAL         = 4'h0;
  localparam logic [3:0] EST_ESPERA          = 4'h1;
  localparam logic [3:0] EST_INICIO_RODADA   = 4'h2;
  localparam logic [3:0] EST_PREPARACAO      = 4'h3;
  localparam logic [3:0] EST_REGISTRA        = 4'h4;
  localparam logic [3:0] EST_COMPARACAO      = 4'h5;
  localparam logic [3:0] EST_PROXIMA_JOGADA  = 4'h6;
  localparam logic [3:0] EST_ULTIMA_RODADA   = 4'h7;
  localparam logic [3:0] EST_PROXIMA_RODADA  = 4'h8;
  localparam logic [3:0] EST_ESPERA_ESCRITA  = 4'h9;
  localparam logic [3:0] EST_ESCREVE         = 4'hA;
  localparam logic [3:0] EST_TOUT            = 4'hB;
  localparam logic [3:0] EST_PERDE_VIDA      = 4'hC;
  localparam logic [3:0] EST_VITORIA         = 4'hD;
  localparam logic [3:0] EST_DERROTA         = 4'hE;
  localparam logic [3:0] EST_INVALIDO        = 4'hF;

  typedef enum logic [3:0] {
    StInicial       = EST_INICIAL,
    StEspera        = EST_ESPERA,
    StInicioRodada  = EST_INICIO_RODADA,
    StPreparacao    = EST_PREPARACAO,
    StRegistra      = EST_REGISTRA,
    StComparacao    = EST_COMPARACAO,
    StProximaJogada = EST_PROXIMA_JOGADA,
    StUltimaRodada  = EST_ULTIMA_RODADA,
    StProximaRodada = EST_PROXIMA_RODADA,
    StEsperaEscrita = EST_ESPERA_ESCRITA,
    StEscreve       = EST_ESCREVE,
    StTout          = EST_TOUT,
    StPerdeVida     = EST_PERDE_VIDA,
    StVitoria       = EST_VITORIA,
    StDerrota       = EST_DERROTA
  } estado_e;

  localparam logic [1:0] MODO_CLASSICO    = 2'b00;
  localparam logic [1:0] MODO_SEM_TIMEOUT = 2'b01;
  localparam logic [1:0] MODO_ESCRITA     = 2'b10;

endpackage

// File: rtl/contador_timeout.sv
// Saturating wait-cycle counter; fim flags the last allowed cycle before timeout.
module contador_timeout #(
  parameter int unsigned TIMEOUT_CICLOS = 5000,
  parameter int unsigned W_TIMEOUT      = 13
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam logic [W_TIMEOUT-1:0] Ultimo = W_TIMEOUT'(TIMEOUT_CICLOS - 1);

  logic [W_TIMEOUT-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (zera) begin
      cnt_d = '0;
    end else if (conta && (cnt_q != Ultimo)) begin
      cnt_d = cnt_q + W_TIMEOUT'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fim = (cnt_q == Ultimo);

endmodule

// File: rtl/unidade_controle_vidas.sv
// Moore controller for the sequence game with lives, wait timeout and a latched game mode.
module unidade_controle_vidas
  import controle_pkg::*;
#(
  parameter int unsigned TIMEOUT_CICLOS = 5000,
  parameter int unsigned VIDAS          = 3,
  parameter int unsigned W_VIDAS        = 2,
  parameter int unsigned W_TIMEOUT      = 13
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iniciar,
  input  logic [1:0]         modo,
  input  logic               fimCR,
  input  logic               jogada,
  input  logic               enderecoIgualRodada,
  input  logic               jogada_correta,
  output logic               zeraCE,
  output logic               contaCE,
  output logic               zeraCR,
  output logic               contaCR,
  output logic               zeraR,
  output logic               registraR,
  output logic               escreveM,
  output logic               pronto,
  output logic               errou,
  output logic               acertou,
  output logic [3:0]         db_estado,
  output logic [W_VIDAS-1:0] db_vidas,
  output logic               db_timeout
);

  localparam logic [W_VIDAS-1:0] VidasIni = W_VIDAS'(VIDAS);

  estado_e              estado_q, estado_d;
  logic [1:0]           modo_q, modo_d;
  logic [W_VIDAS-1:0]   vidas_q, vidas_d;
  logic                 em_espera, fim_timeout, timeout, ultima_vida, aceita_inicio;

  assign em_espera     = (estado_q == StEspera) || (estado_q == StEsperaEscrita);
  assign timeout       = fim_timeout && (modo_q != MODO_SEM_TIMEOUT);
  assign ultima_vida   = (vidas_q == W_VIDAS'(1));
  assign aceita_inicio = (estado_q == StInicial) || (estado_q == StDerrota) ||
                         (estado_q == StVitoria) || (estado_q == StTout);

  contador_timeout #(
    .TIMEOUT_CICLOS (TIMEOUT_CICLOS),
    .W_TIMEOUT      (W_TIMEOUT)
  ) u_timeout (
    .clock (clock),
    .reset (reset),
    .zera  (!em_espera),
    .conta (em_espera),
    .fim   (fim_timeout)
  );

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      StInicial, StDerrota, StVitoria, StTout: begin
        if (iniciar) estado_d = StPreparacao;
      end
      StPreparacao:    estado_d = StInicioRodada;
      StInicioRodada:  estado_d = StEspera;
      StEspera, StEsperaEscrita: begin
        // Timeout outranks a jogada arriving in the same cycle.
        if (timeout) begin
          estado_d = ultima_vida ? StTout : StPerdeVida;
        end else if (jogada) begin
          estado_d = (estado_q == StEspera) ? StRegistra : StEscreve;
        end
      end
      StRegistra:      estado_d = StComparacao;
      StComparacao: begin
        if (!jogada_correta) begin
          estado_d = ultima_vida ? StDerrota : StPerdeVida;
        end else if (enderecoIgualRodada) begin
          estado_d = StUltimaRodada;
        end else begin
          estado_d = StProximaJogada;
        end
      end
      StProximaJogada: estado_d = StEspera;
      StUltimaRodada: begin
        if (fimCR) begin
          estado_d = StVitoria;
        end else if (modo_q == MODO_ESCRITA) begin
          estado_d = StEsperaEscrita;
        end else begin
          estado_d = StProximaRodada;
        end
      end
      StEscreve:       estado_d = StProximaRodada;
      StProximaRodada: estado_d = StInicioRodada;
      StPerdeVida:     estado_d = StInicioRodada;
      default:         estado_d = StInicial;
    endcase
  end

  always_comb begin
    modo_d  = modo_q;
    vidas_d = vidas_q;
    if (aceita_inicio && iniciar) begin
      modo_d = ((modo == MODO_SEM_TIMEOUT) || (modo == MODO_ESCRITA)) ? modo : MODO_CLASSICO;
    end
    if (estado_q == StPreparacao) begin
      vidas_d = VidasIni;
    end else if (estado_d == StPerdeVida) begin
      // Decrement on entry so db_vidas already shows the reduced count in perde_vida.
      vidas_d = vidas_q - W_VIDAS'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= StInicial;
      modo_q   <= MODO_CLASSICO;
      vidas_q  <= VidasIni;
    end else begin
      estado_q <= estado_d;
      modo_q   <= modo_d;
      vidas_q  <= vidas_d;
    end
  end

  always_comb begin
    zeraCE    = 1'b0;
    contaCE   = 1'b0;
    zeraCR    = 1'b0;
    contaCR   = 1'b0;
    zeraR     = 1'b0;
    registraR = 1'b0;
    escreveM  = 1'b0;
    pronto    = 1'b0;
    errou     = 1'b0;
    acertou   = 1'b0;
    db_estado = estado_q;
    case (estado_q)
      StInicial, StPreparacao: begin
        zeraCE = 1'b1;
        zeraCR = 1'b1;
        zeraR  = 1'b1;
      end
      StInicioRodada:  zeraCE = 1'b1;
      StProximaJogada: contaCE = 1'b1;
      StRegistra:      registraR = 1'b1;
      StEscreve: begin
        contaCE   = 1'b1;
        registraR = 1'b1;
        escreveM  = 1'b1;
      end
      StProximaRodada: contaCR = 1'b1;
      StDerrota, StTout: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
      StVitoria: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      StEspera, StComparacao, StUltimaRodada, StEsperaEscrita, StPerdeVida: ;
      default: db_estado = EST_INVALIDO;
    endcase
  end

  assign db_vidas   = vidas_q;
  assign db_timeout = fim_timeout;

endmodule

// File: tb/tb_unidade_controle_vidas.sv
// Directed bench for unidade_controle_vidas with an 8-cycle timeout and three lives.
module tb_unidade_controle_vidas;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic [1:0] modo = 2'b00;
  logic       fimCR = 1'b0;
  logic       jogada = 1'b0;
  logic       enderecoIgualRodada = 1'b0;
  logic       jogada_correta = 1'b0;
  logic       zeraCE, contaCE, zeraCR, contaCR, zeraR, registraR, escreveM;
  logic       pronto, errou, acertou, db_timeout;
  logic [3:0] db_estado;
  logic [1:0] db_vidas;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  unidade_controle_vidas #(
    .TIMEOUT_CICLOS (8),
    .VIDAS          (3),
    .W_VIDAS        (2),
    .W_TIMEOUT      (4)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .iniciar             (iniciar),
    .modo                (modo),
    .fimCR               (fimCR),
    .jogada              (jogada),
    .enderecoIgualRodada (enderecoIgualRodada),
    .jogada_correta      (jogada_correta),
    .zeraCE              (zeraCE),
    .contaCE             (contaCE),
    .zeraCR              (zeraCR),
    .contaCR             (contaCR),
    .zeraR               (zeraR),
    .registraR           (registraR),
    .escreveM            (escreveM),
    .pronto              (pronto),
    .errou               (errou),
    .acertou             (acertou),
    .db_estado           (db_estado),
    .db_vidas            (db_vidas),
    .db_timeout          (db_timeout)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_jogada();
    jogada = 1'b1;
    tick();
    jogada = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    tick();
    tick();
    nvec++;
    if (db_estado !== 4'h0) begin
      nerr++; $display("FAIL reset_estado: got %h expected 0", db_estado);
    end
    nvec++;
    if ({zeraCE, zeraCR, zeraR} !== 3'b111) begin
      nerr++; $display("FAIL reset_zeras: got %b expected 111", {zeraCE, zeraCR, zeraR});
    end
    nvec++;
    if ({contaCE, contaCR, registraR, escreveM, pronto, errou, acertou} !== 7'b0) begin
      nerr++; $display("FAIL reset_outros: got %b expected 0000000",
                       {contaCE, contaCR, registraR, escreveM, pronto, errou, acertou});
    end
    nvec++;
    if (db_vidas !== 2'd3) begin
      nerr++; $display("FAIL reset_vidas: got %0d expected 3", db_vidas);
    end
    reset = 1'b0;
  endtask

  task automatic test_vitoria();
    modo = 2'b00;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    nvec++;
    if (db_estado !== 4'h3) begin
      nerr++; $display("FAIL vit_preparacao: got %h expected 3", db_estado);
    end
    tick();
    nvec++;
    if ({db_estado, zeraCE} !== 5'b0010_1) begin
      nerr++; $display("FAIL vit_inicio_rodada: got %h/%b expected 2/1", db_estado, zeraCE);
    end
    tick();
    jogada_correta = 1'b1; enderecoIgualRodada = 1'b1; fimCR = 1'b0;
    pulse_jogada();
    nvec++;
    if ({db_estado, registraR} !== 5'b0100_1) begin
      nerr++; $display("FAIL vit_registra: got %h/%b expected 4/1", db_estado, registraR);
    end
    tick();
    tick();
    tick();
    nvec++;
    if ({db_estado, contaCR} !== 5'b1000_1) begin
      nerr++; $display("FAIL vit_proxima_rodada: got %h/%b expected 8/1", db_estado, contaCR);
    end
    tick();
    tick();
    enderecoIgualRodada = 1'b0;
    pulse_jogada();
    tick();
    tick();
    nvec++;
    if ({db_estado, contaCE} !== 5'b0110_1) begin
      nerr++; $display("FAIL vit_proxima_jogada: got %h/%b expected 6/1", db_estado, contaCE);
    end
    tick();
    enderecoIgualRodada = 1'b1;
    pulse_jogada();
    fimCR = 1'b1;
    tick();
    tick();
    tick();
    nvec++;
    if ({db_estado, pronto, acertou, errou, db_vidas} !== 9'b1101_1_1_0_11) begin
      nerr++; $display("FAIL vit_final: got %h p%b a%b e%b v%0d expected D p1 a1 e0 v3",
                       db_estado, pronto, acertou, errou, db_vidas);
    end
    fimCR = 1'b0;
  endtask

  task automatic test_perde_vida();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
    tick();
    jogada_correta = 1'b1; enderecoIgualRodada = 1'b1;
    pulse_jogada();
    tick(); tick(); tick(); tick(); tick();
    jogada_correta = 1'b0;
    pulse_jogada();
    tick();
    tick();
    nvec++;
    if ({db_estado, contaCR, db_vidas} !== 7'b1100_0_10) begin
      nerr++; $display("FAIL pv_perde_vida: got %h c%b v%0d expected C c0 v2",
                       db_estado, contaCR, db_vidas);
    end
    tick();
    nvec++;
    if ({db_estado, zeraCE, contaCR, db_vidas} !== 8'b0010_1_0_10) begin
      nerr++; $display("FAIL pv_replay: got %h z%b c%b v%0d expected 2 z1 c0 v2",
                       db_estado, zeraCE, contaCR, db_vidas);
    end
    tick();
    jogada_correta = 1'b1;
  endtask

  task automatic test_timeout();
    repeat (7) tick();
    nvec++;
    if ({db_estado, db_timeout} !== 5'b0001_1) begin
      nerr++; $display("FAIL to_ultimo_ciclo: got %h/%b expected 1/1", db_estado, db_timeout);
    end
    tick();
    nvec++;
    if ({db_estado, db_vidas} !== 6'b1100_01) begin
      nerr++; $display("FAIL to_perde_vida: got %h v%0d expected C v1", db_estado, db_vidas);
    end
    tick();
    tick();
    repeat (7) tick();
    nvec++;
    if (db_estado !== 4'h1) begin
      nerr++; $display("FAIL to_espera7: got %h expected 1", db_estado);
    end
    jogada = 1'b1;
    tick();
    jogada = 1'b0;
    nvec++;
    if ({db_estado, pronto, errou, acertou, db_vidas} !== 9'b1011_1_1_0_01) begin
      nerr++; $display("FAIL to_tout: got %h p%b e%b a%b v%0d expected B p1 e1 a0 v1",
                       db_estado, pronto, errou, acertou, db_vidas);
    end
  endtask

  task automatic test_sem_timeout();
    modo = 2'b01;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 100; i++) begin
      tick();
      nvec++;
      if (db_estado !== 4'h1) begin
        nerr++; $display("FAIL st_espera ciclo %0d: got %h expected 1", i, db_estado);
      end
    end
    jogada_correta = 1'b1; enderecoIgualRodada = 1'b1; fimCR = 1'b1;
    pulse_jogada();
    tick();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    nvec++;
    if (db_estado !== 4'h7) begin
      nerr++; $display("FAIL st_iniciar_ignorado: got %h expected 7", db_estado);
    end
    tick();
    nvec++;
    if ({db_estado, db_vidas} !== 6'b1101_11) begin
      nerr++; $display("FAIL st_vitoria: got %h v%0d expected D v3", db_estado, db_vidas);
    end
    fimCR = 1'b0;
  endtask

  task automatic test_escrita();
    modo = 2'b10;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    modo = 2'b00;
    tick();
    tick();
    jogada_correta = 1'b1; enderecoIgualRodada = 1'b1; fimCR = 1'b0;
    pulse_jogada();
    tick();
    tick();
    tick();
    nvec++;
    if (db_estado !== 4'h9) begin
      nerr++; $display("FAIL esc_espera_escrita: got %h expected 9", db_estado);
    end
    pulse_jogada();
    nvec++;
    if ({db_estado, escreveM, registraR, contaCE} !== 7'b1010_111) begin
      nerr++; $display("FAIL esc_escreve: got %h w%b r%b c%b expected A w1 r1 c1",
                       db_estado, escreveM, registraR, contaCE);
    end
    tick();
    nvec++;
    if ({db_estado, escreveM, registraR, contaCE, contaCR} !== 8'b1000_0001) begin
      nerr++; $display("FAIL esc_proxima_rodada: got %h w%b r%b c%b cr%b expected 8 w0 r0 c0 cr1",
                       db_estado, escreveM, registraR, contaCE, contaCR);
    end
    tick();
    tick();
    jogada_correta = 1'b0;
    pulse_jogada();
    tick();
    tick();
    nvec++;
    if ({db_estado, db_vidas} !== 6'b1100_10) begin
      nerr++; $display("FAIL esc_perde_vida: got %h v%0d expected C v2", db_estado, db_vidas);
    end
    jogada_correta = 1'b1;
    tick();
    tick();
    pulse_jogada();
    tick(); tick(); tick();
    pulse_jogada();
    nvec++;
    if ({db_estado, escreveM} !== 5'b1010_1) begin
      nerr++; $display("FAIL esc_escreve2: got %h/%b expected A/1", db_estado, escreveM);
    end
    #2 reset = 1'b1;
    #1;
    nvec++;
    if ({db_estado, escreveM, db_vidas} !== 7'b0000_0_11) begin
      nerr++; $display("FAIL esc_reset_async: got %h w%b v%0d expected 0 w0 v3",
                       db_estado, escreveM, db_vidas);
    end
    tick();
    reset = 1'b0;
    nvec++;
    if ({db_estado, escreveM, pronto} !== 6'b0000_0_0) begin
      nerr++; $display("FAIL esc_reset_held: got %h w%b p%b expected 0 w0 p0",
                       db_estado, escreveM, pronto);
    end
  endtask

  initial begin
    test_reset();
    test_vitoria();
    test_perde_vida();
    test_timeout();
    test_sem_timeout();
    test_escrita();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
